pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline stage register for the CPU datapath, generalising the fixed-field stage flip-flop between pipeline stages (ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle with a valid/ready handshake, and uses a one-entry skid buffer so that it sustains full throughput without a combinational ready path. It also provides flush, bubble-safe control gating and a saturating bubble counter for stall profiling.

---
 rtl/pipe_stage_skid.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Elastic pipeline stage register for the CPU datapath. It generalises the
// fixed-field stage flip-flop found between ID/EX, EX/MEM and MEM/WB into a
// valid/ready stage that carries a control bundle and a data bundle.
//
// A one-entry skid register lets the stage keep accepting at full rate while
// in_ready is decoded purely from registered state. Without it, in_ready would
// need a combinational path from out_ready. The stage also provides:
//   - flush: drops every held entry and any entry accepted in the same cycle
//   - control gating: a bubble never drives live control bits downstream
//   - a saturating bubble counter for stall profiling
//
// Parameters
//   CTRL_W      control bundle width (default packs RegDst, ALUOp1, ALUOp0,
//               ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg)
//   DATA_W      data bundle width (sign-extended immediate, register ids, ...)
//   CNT_W       bubble counter width
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream presents a valid instruction
//   in_ready    stage can accept this cycle
//   in_ctrl     upstream control bundle
//   in_data     upstream data bundle
//   flush       discard all held and incoming entries
//   out_valid   downstream entry valid
//   out_ready   downstream consumes this cycle
//   out_ctrl    control bundle, forced to zero while out_valid is low
//   out_data    data bundle, keeps the last loaded value while invalid
//   bubble_clr  clear the bubble counter (wins over an increment)
//   bubble_cnt  cycles with out_ready high and out_valid low, saturating
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              bubble_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Occupancy of the stage. ONE means only the main register holds an
    // entry. TWO means the skid register holds the younger entry as well.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_bubble_cnt;

    logic                w_accept;
    logic                w_consume;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;
    logic                w_bubble;
    logic                w_cnt_max;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // in_ready depends only on the registered state and on rst. It never
    // looks at out_ready or flush, so the upstream ready path stays short.
    assign in_ready  = (r_state != S_TWO) && !rst;
    assign out_valid = (r_state != S_EMPTY);

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state and load-enable decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first. A path that
        // forgot to assign one would otherwise infer a latch.
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        unique case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_consume) begin
                    // Head leaves and the newcomer takes its place directly.
                    w_next_state   = S_ONE;
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    // Downstream stalled: park the newcomer behind the head.
                    w_next_state = S_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_consume) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a consume can move things.
                if (w_consume) begin
                    w_next_state     = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase

        // Flush overrides everything. Loads are suppressed as well, so an
        // entry accepted in the flush cycle never reaches out_data.
        if (flush) begin
            w_next_state     = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end

            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bubble counter
    // ------------------------------------------------------------------
    // A bubble is a cycle where downstream could take an entry but none is
    // offered. Flush does not touch the count.
    assign w_bubble  = out_ready && !out_valid;
    assign w_cnt_max = &r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (bubble_clr) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && !w_cnt_max) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gating the control bundle means a bubble can never assert RegWrite,
    // MemWrite or Branch downstream. The data bundle is left ungated.
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Self-checking bench for pipe_stage_skid (CTRL_W=9, DATA_W=32, CNT_W=4).
//
// The reference model is a queue of in-flight entries:
//   - the head drives out_*
//   - in_ready is "fewer than two entries held and not in reset"
//   - the last head data value is kept for out_data while the stage is empty
//
// A negedge process compares every DUT output with the model on every cycle.
// The directed sequences also pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int CTRL_W  = 9;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              bubble_clr;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .bubble_clr(bubble_clr),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and check task
    // ------------------------------------------------------------------
    int n_vectors     = 0;
    int n_miscompares = 0;
    bit chk_en        = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t            m_q[$];
    logic [DATA_W-1:0] m_hold;
    int                m_bub;

    initial begin
        m_hold = '0;
        m_bub  = 0;
    end

    always @(posedge clk) begin
        bit     acc;
        bit     cons;
        bit     bub;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_hold = '0;
            m_bub  = 0;
        end else begin
            acc  = in_valid && (m_q.size() < 2);
            cons = (m_q.size() > 0) && out_ready;
            bub  = out_ready && (m_q.size() == 0);

            if (bubble_clr)                 m_bub = 0;
            else if (bub && m_bub < CNT_MAX) m_bub = m_bub + 1;

            if (flush) begin
                m_q.delete();
            end else begin
                if (cons) m_q.delete(0);
                if (acc) begin
                    e.c = in_ctrl;
                    e.d = in_data;
                    m_q.push_back(e);
                end
            end

            if (m_q.size() > 0) m_hold = m_q[0].d;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic              exp_rdy;
        logic              exp_vld;
        logic [CTRL_W-1:0] exp_ctrl;
        logic [DATA_W-1:0] exp_data;
        if (chk_en) begin
            exp_rdy  = (m_q.size() < 2) && !rst;
            exp_vld  = (m_q.size() > 0);
            exp_ctrl = exp_vld ? m_q[0].c : '0;
            exp_data = exp_vld ? m_q[0].d : m_hold;
            check("in_ready",   64'(in_ready),   64'(exp_rdy));
            check("out_valid",  64'(out_valid),  64'(exp_vld));
            check("out_ctrl",   64'(out_ctrl),   64'(exp_ctrl));
            check("out_data",   64'(out_data),   64'(exp_data));
            check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic fill_two(input logic [CTRL_W-1:0] ca, input logic [DATA_W-1:0] da,
                            input logic [CTRL_W-1:0] cb, input logic [DATA_W-1:0] db);
        drive(1'b1, ca, da, 1'b0);
        tick();
        drive(1'b1, cb, db, 1'b0);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        bubble_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Power-on reset
        tick();
        chk_en = 1'b1;
        check("rst_in_ready",   64'(in_ready),   64'd0);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_ctrl",   64'(out_ctrl),   64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming at full rate. The clear absorbs the bubble of the first
        // edge, where nothing is held yet.
        bubble_clr = 1'b1;
        drive(1'b1, 9'h1A3, 32'h1111_0001, 1'b1);
        tick();
        bubble_clr = 1'b0;
        check("stream0_ctrl",  64'(out_ctrl), 64'h1A3);
        check("stream0_valid", 64'(out_valid), 64'd1);
        check("stream0_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 9'h0F0, 32'h1111_0002, 1'b1);
        tick();
        check("stream1_ctrl",  64'(out_ctrl), 64'h0F0);
        check("stream1_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 9'h155, 32'h1111_0003, 1'b1);
        tick();
        check("stream2_ctrl",  64'(out_ctrl), 64'h155);
        check("stream2_data",  64'(out_data), 64'h1111_0003);
        check("stream_bubble", 64'(bubble_cnt), 64'd0);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_ctrl",  64'(out_ctrl), 64'd0);
        check("drain_data",  64'(out_data), 64'h1111_0003);

        // Backpressure: A and B fill main and skid. C must be refused.
        fill_two(9'h0A5, 32'hAAAA_0000, 9'h05A, 32'hBBBB_0000);
        check("bp_in_ready_two", 64'(in_ready), 64'd0);
        check("bp_head_a",       64'(out_ctrl), 64'h0A5);
        drive(1'b1, 9'h0CC, 32'hCCCC_0000, 1'b0);
        tick();
        check("bp_hold_a", 64'(out_ctrl), 64'h0A5);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check("bp_head_b",   64'(out_ctrl), 64'h05A);
        check("bp_ready_up", 64'(in_ready), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush in TWO with in_valid asserted
        fill_two(9'h111, 32'hD00D_0001, 9'h122, 32'hD00D_0002);
        flush = 1'b1;
        drive(1'b1, 9'h133, 32'hD00D_0003, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl",  64'(out_ctrl), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);

        // Flush in ONE while accepting: the newcomer is dropped too
        drive(1'b1, 9'h144, 32'hE000_0001, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 9'h155, 32'hE000_0002, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("flush1_valid", 64'(out_valid), 64'd0);
        check("flush1_data",  64'(out_data), 64'hE000_0001);

        // Bubble gating and counting
        drive(1'b1, 9'h1FF, 32'h5A5A_F00D, 1'b0);
        tick();
        bubble_clr = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        tick();
        bubble_clr = 1'b0;
        check("gate_valid",  64'(out_valid), 64'd0);
        check("gate_ctrl",   64'(out_ctrl), 64'd0);
        check("gate_data",   64'(out_data), 64'h5A5A_F00D);
        check("gate_bubble0", 64'(bubble_cnt), 64'd0);
        tick();
        check("gate_bubble1", 64'(bubble_cnt), 64'd1);
        tick();
        check("gate_bubble2", 64'(bubble_cnt), 64'd2);

        // Counter saturation, then clear while incrementing
        bubble_clr = 1'b1;
        tick();
        bubble_clr = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("cnt_saturate", 64'(bubble_cnt), 64'd15);
        bubble_clr = 1'b1;
        tick();
        bubble_clr = 1'b0;
        check("cnt_clear", 64'(bubble_cnt), 64'd0);

        // Reset mid-stream in TWO
        fill_two(9'h0AB, 32'h7777_0001, 9'h0CD, 32'h7777_0002);
        rst = 1'b1;
        drive(1'b1, 9'h0EF, 32'h7777_0003, 1'b1);
        tick();
        check("mrst_valid",  64'(out_valid), 64'd0);
        check("mrst_ctrl",   64'(out_ctrl), 64'd0);
        check("mrst_data",   64'(out_data), 64'd0);
        check("mrst_bubble", 64'(bubble_cnt), 64'd0);
        check("mrst_ready",  64'(in_ready), 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("mrst_ready_up", 64'(in_ready), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_ctrl    = CTRL_W'($urandom_range(0, (1 << CTRL_W) - 1));
            in_data    = $urandom();
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            bubble_clr = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst        = 1'b0;
        flush      = 1'b0;
        bubble_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vectors, n_miscompares);
        $finish;
    end

endmodule
